// File: rtl/morse_decoder.sv
// Morse receiver: classifies strobed marks and gaps into dots and dashes, then decodes letters A..H.
// Define MORSE_DEC_STATS_EN to add the LetterCount/ErrorCount statistics outputs.
module morse_decoder #(
  parameter int unsigned DASH_UNITS = 3,
  parameter int unsigned GAP_UNITS  = 3,
  parameter int unsigned MAX_SYMS   = 4
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       DotDashIn,
  input  logic       NewBitIn,
  output logic [2:0] Letter,
  output logic       LetterValid,
`ifdef MORSE_DEC_STATS_EN
  output logic       ErrorOut,
  output logic [7:0] LetterCount,
  output logic [7:0] ErrorCount
`else
  output logic       ErrorOut
`endif
);

  localparam int unsigned RUN_SAT = DASH_UNITS + 1;
  localparam int unsigned RUN_MAX = (RUN_SAT > GAP_UNITS) ? RUN_SAT : GAP_UNITS;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] DASH_R  = RUN_W'(DASH_UNITS);
  localparam logic [RUN_W-1:0] SAT_R   = RUN_W'(RUN_SAT);
  localparam logic [RUN_W-1:0] GAP_R   = RUN_W'(GAP_UNITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
    S_DRAIN
  } state_t;

  state_t           state;
  logic [RUN_W-1:0] run;
  logic [2:0]       sym_cnt;
  logic [3:0]       sym_reg;

  logic [RUN_W-1:0] run_inc;
  logic [3:0]       cnt_inc;
  logic             is_dot;
  logic             is_dash;
  logic             too_many;
  logic [3:0]       app_reg;
  logic             dec_hit;
  logic [2:0]       dec_code;

  always_comb begin
    run_inc  = run + RUN_ONE;
    cnt_inc  = {1'b0, sym_cnt} + 4'd1;
    is_dot   = (run == RUN_ONE);
    is_dash  = (run == DASH_R);
    too_many = (cnt_inc > 4'(MAX_SYMS));
    app_reg  = {sym_reg[2:0], ~is_dot};
  end

  // Register is cleared on every return to IDLE, so unused upper bits are always zero.
  always_comb begin
    dec_hit  = 1'b1;
    dec_code = '0;
    case ({sym_cnt, sym_reg})
      {3'd2, 4'b0001}: dec_code = 3'd0;
      {3'd4, 4'b1000}: dec_code = 3'd1;
      {3'd4, 4'b1010}: dec_code = 3'd2;
      {3'd3, 4'b0100}: dec_code = 3'd3;
      {3'd1, 4'b0000}: dec_code = 3'd4;
      {3'd4, 4'b0010}: dec_code = 3'd5;
      {3'd3, 4'b0110}: dec_code = 3'd6;
      {3'd4, 4'b0000}: dec_code = 3'd7;
      default:         dec_hit  = 1'b0;
    endcase
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state       <= S_IDLE;
      run         <= '0;
      sym_cnt     <= '0;
      sym_reg     <= '0;
      Letter      <= '0;
      LetterValid <= 1'b0;
      ErrorOut    <= 1'b0;
    end else begin
      LetterValid <= 1'b0;
      ErrorOut    <= 1'b0;
      if (NewBitIn) begin
        case (state)
          S_IDLE: begin
            if (DotDashIn) begin
              state <= S_MARK;
              run   <= RUN_ONE;
            end
          end
          S_MARK: begin
            if (DotDashIn) begin
              if (run != SAT_R) run <= run_inc;
            end else if (!(is_dot || is_dash) || too_many) begin
              ErrorOut <= 1'b1;
              state    <= S_DRAIN;
              run      <= '0;
              sym_cnt  <= '0;
              sym_reg  <= '0;
            end else begin
              sym_reg <= app_reg;
              sym_cnt <= cnt_inc[2:0];
              state   <= S_SPACE;
              run     <= RUN_ONE;
            end
          end
          S_SPACE: begin
            if (!DotDashIn) begin
              if (run_inc >= GAP_R) begin
                if (dec_hit) begin
                  Letter      <= dec_code;
                  LetterValid <= 1'b1;
                end else begin
                  ErrorOut <= 1'b1;
                end
                state   <= S_IDLE;
                run     <= '0;
                sym_cnt <= '0;
                sym_reg <= '0;
              end else begin
                run <= run_inc;
              end
            end else if (run == RUN_ONE) begin
              state <= S_MARK;
              run   <= RUN_ONE;
            end else begin
              ErrorOut <= 1'b1;
              state    <= S_DRAIN;
              run      <= '0;
              sym_cnt  <= '0;
              sym_reg  <= '0;
            end
          end
          S_DRAIN: begin
            if (DotDashIn) begin
              run <= '0;
            end else if (run_inc >= GAP_R) begin
              state <= S_IDLE;
              run   <= '0;
            end else begin
              run <= run_inc;
            end
          end
          default: begin
            state   <= S_IDLE;
            run     <= '0;
            sym_cnt <= '0;
            sym_reg <= '0;
          end
        endcase
      end
    end
  end

`ifdef MORSE_DEC_STATS_EN
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      LetterCount <= '0;
      ErrorCount  <= '0;
    end else begin
      if (LetterValid) LetterCount <= LetterCount + 8'd1;
      if (ErrorOut)    ErrorCount  <= ErrorCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_morse_decoder.sv
// Randomised bench for morse_decoder against a run-length reference model of the sample stream.
module tb_morse_decoder;

  localparam int unsigned DASH = 3;
  localparam int unsigned GAP  = 3;
  localparam int unsigned MAXS = 4;

  logic       ClockIn = 1'b0;
  logic       Reset = 1'b1;
  logic       DotDashIn = 1'b0;
  logic       NewBitIn = 1'b0;
  logic [2:0] Letter;
  logic       LetterValid;
  logic       ErrorOut;

  morse_decoder #(
    .DASH_UNITS(DASH),
    .GAP_UNITS (GAP),
    .MAX_SYMS  (MAXS)
  ) dut (
    .ClockIn    (ClockIn),
    .Reset      (Reset),
    .DotDashIn  (DotDashIn),
    .NewBitIn   (NewBitIn),
    .Letter     (Letter),
    .LetterValid(LetterValid),
    .ErrorOut   (ErrorOut)
  );

  always #5 ClockIn = ~ClockIn;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  string codes[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  // Reference model: samples of the current letter are kept verbatim and judged by run lengths.
  bit          q[$];
  bit          m_drain;
  int unsigned m_zc;
  logic [2:0]  exp_letter;
  logic        exp_valid;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    q.delete();
    m_drain    = 1'b0;
    m_zc       = 0;
    exp_letter = '0;
    exp_valid  = 1'b0;
    exp_err    = 1'b0;
  endfunction

  function automatic void model_sample(input bit b);
    int    n;
    int    len;
    int    marks;
    bit    bad;
    bit    found;
    string pat;
    if (m_drain) begin
      if (b) m_zc = 0;
      else m_zc++;
      if (m_zc >= GAP) m_drain = 1'b0;
      return;
    end
    if (q.size() == 0 && !b) return;
    q.push_back(b);
    n   = q.size();
    bad = 1'b0;
    if (n < 2) return;
    if (!b && q[n-2]) begin
      len = 0;
      for (int i = n - 2; i >= 0 && q[i]; i--) len++;
      marks = 0;
      for (int i = 0; i < n; i++) if (q[i] && (i == 0 || !q[i-1])) marks++;
      bad = (len != 1 && len != int'(DASH)) || marks > int'(MAXS);
    end else if (b && !q[n-2]) begin
      len = 0;
      for (int i = n - 2; i >= 0 && !q[i]; i--) len++;
      bad = len > 1;
    end else if (!b) begin
      len = 0;
      for (int i = n - 1; i >= 0 && !q[i]; i--) len++;
      if (len == int'(GAP)) begin
        pat = "";
        len = 0;
        for (int i = 0; i < n; i++) begin
          if (q[i]) len++;
          else begin
            if (len == 1) pat = {pat, "."};
            else if (len > 1) pat = {pat, "-"};
            len = 0;
          end
        end
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (pat == codes[k]) begin
            exp_letter = 3'(k);
            found      = 1'b1;
          end
        end
        if (found) exp_valid = 1'b1;
        else exp_err = 1'b1;
        q.delete();
        return;
      end
    end
    if (bad) begin
      exp_err = 1'b1;
      m_drain = 1'b1;
      m_zc    = 0;
      q.delete();
    end
  endfunction

  task automatic step(input logic rst, input logic nb, input logic b);
    @(negedge ClockIn);
    Reset     = rst;
    NewBitIn  = nb;
    DotDashIn = b;
    @(posedge ClockIn);
    if (rst) model_reset();
    else begin
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (nb) model_sample(b);
    end
    #1;
    check("letter", 32'(Letter), 32'(exp_letter));
    check("valid", 32'(LetterValid), 32'(exp_valid));
    check("error", 32'(ErrorOut), 32'(exp_err));
    check("exclusive", 32'(LetterValid & ErrorOut), 32'd0);
  endtask

  task automatic send(input logic b, input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'($urandom));
    end
    step(1'b0, 1'b1, b);
  endtask

  task automatic send_list(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) send(s[i] == "1", gaps);
  endtask

  task automatic send_code(input string pat, input bit gaps);
    for (int j = 0; j < pat.len(); j++) begin
      if (pat[j] == "-") send_list("1110", gaps);
      else send_list("10", gaps);
    end
    send_list("00", gaps);
  endtask

  initial begin
    string pat;
    model_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("rst_letter", 32'(Letter), 32'd0);
    check("rst_valid", 32'(LetterValid), 32'd0);
    check("rst_error", 32'(ErrorOut), 32'd0);

    send_list("10111000", 1'b0);
    check("A_valid", 32'(LetterValid), 32'd1);
    check("A_letter", 32'(Letter), 32'd0);

    send_list("11101011101000", 1'b0);
    check("C_valid", 32'(LetterValid), 32'd1);
    check("C_letter", 32'(Letter), 32'd2);

    send_list("110", 1'b0);
    check("mark2_err", 32'(ErrorOut), 32'd1);
    send_list("001000", 1'b0);
    send_list("1000", 1'b0);
    check("drain_exit_E", 32'(Letter), 32'd4);

    send_list("1010101010", 1'b0);
    check("five_dots_err", 32'(ErrorOut), 32'd1);
    send_list("000", 1'b0);

    send_list("101", 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("midrst_letter", 32'(Letter), 32'd0);
    send_list("1000", 1'b0);
    check("rst_then_E", 32'(Letter), 32'd4);

    send_list("11", 1'b0);
    repeat (50) step(1'b0, 1'b0, 1'($urandom));
    send_list("10101000", 1'b0);
    check("hold_D_valid", 32'(LetterValid), 32'd1);
    check("hold_D_letter", 32'(Letter), 32'd3);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 49) == 0) step(1'b1, 1'($urandom), 1'($urandom));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: send_code(codes[$urandom_range(0, 7)], 1'b1);
        6, 7: begin
          pat = "";
          repeat ($urandom_range(1, 5)) pat = {pat, ($urandom_range(0, 1) == 1) ? "-" : "."};
          send_code(pat, 1'b1);
        end
        default: repeat ($urandom_range(1, 12)) send(1'($urandom), 1'b1);
      endcase
    end
    send_list("000", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
- Receive-side partner of the Morse transmitter. Consumes the transmitter's serial dot/dash stream and its per-unit strobe.
- Recovers the 3-bit letter code (A..H) using the transmitter's 11-bit Morse lookup.
- Delivers the letter as a one-cycle valid pulse to downstream logic (HEX display / loopback checker).
- Malformed timing or unknown symbol sequences produce an error pulse and a resynchronisation.

Parameters:
- DASH_UNITS, 3: mark length, in sample units, that classifies as a dash. A dot is always 1 unit.
- GAP_UNITS, 3: consecutive low samples that terminate a letter.
- MAX_SYMS, 4: maximum dots/dashes per letter. More symbols is an error.

Ports:
- ClockIn, input, 1: system clock; all state changes on its rising edge.
- Reset, input, 1: synchronous, active-high reset.
- DotDashIn, input, 1: serial Morse level from the transmitter; 1 = tone.
- NewBitIn, input, 1: sample strobe, one ClockIn cycle per Morse unit. DotDashIn is sampled only when NewBitIn=1.
- Letter, output, 3: decoded letter code (000=A … 111=H). Holds its value until the next valid letter.
- LetterValid, output, 1: one-cycle pulse; Letter is new this cycle.
- ErrorOut, output, 1: one-cycle pulse; malformed letter discarded.

Behaviour:
- Reset (synchronous, Reset=1 at a rising edge):
  - Letter=000, LetterValid=0, ErrorOut=0.
  - State=IDLE; run counter=0; symbol count=0; symbol register=0.
  - Reset overrides everything, including mid-letter; the partial letter is discarded with no ErrorOut.
- A "sample" is a rising edge with NewBitIn=1. With NewBitIn=0 all state holds and the pulse outputs are 0.
- Symbol register: 4 bits, shifted left, new symbol into LSB; 1=dash, 0=dot. Symbol count is 3 bits.
- State machine:
  - IDLE:
    - sample 1 -> MARK, run=1.
    - sample 0 -> stay in IDLE.
  - MARK:
    - sample 1 -> run+1, saturating at DASH_UNITS+1.
    - sample 0 -> classify the run:
      - run==1 -> append dot.
      - run==DASH_UNITS -> append dash.
      - any other run -> error.
    - After appending, if the symbol count would exceed MAX_SYMS -> error. Otherwise -> SPACE, run=1.
  - SPACE:
    - sample 0 -> run+1. When run reaches GAP_UNITS -> letter end: decode and return to IDLE.
    - sample 1 with run==1 -> MARK, run=1 (intra-letter gap).
    - sample 1 with 1<run<GAP_UNITS -> error.
  - DRAIN (entered on any error):
    - Counts consecutive 0 samples; any 1 sample clears the count.
    - After GAP_UNITS consecutive zeros -> IDLE.
    - No further ErrorOut is raised while in DRAIN.
- Decode at letter end, using (count, pattern):
  - A: (2, 01)
  - B: (4, 1000)
  - C: (4, 1010)
  - D: (3, 100)
  - E: (1, 0)
  - F: (4, 0010)
  - G: (3, 110)
  - H: (4, 0000)
  - Match -> Letter updated and LetterValid=1 in the cycle after the terminating sample edge.
  - No match -> ErrorOut=1 in that cycle, Letter unchanged, -> IDLE directly (the gap is already satisfied).
- Errors detected in MARK/SPACE pulse ErrorOut in the cycle after the offending sample edge, then enter DRAIN.
- Letter end and counters are cleared together: symbol count and register reset to 0 on every exit to IDLE or DRAIN.
- A letter whose transmitter pattern ends in a mark (e.g. C) terminates correctly because the transmitter shifts zeros afterwards.
- Latency: one ClockIn cycle from the GAP_UNITS-th low sample edge to LetterValid.
- LetterValid and ErrorOut are never asserted together.

Optional Feature:
- Macro: MORSE_DEC_STATS_EN.
- Defined:
  - Adds outputs LetterCount[7:0] and ErrorCount[7:0].
  - Each increments on the cycle its pulse is asserted, wrapping 255->0.
  - Both cleared by Reset.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- A (samples 1,0,1,1,1,0,0,0) -> LetterValid=1 with Letter=000, one cycle after the 8th sample; ErrorOut stays 0.
- C (samples 1,1,1,0,1,0,1,1,1,0,1, then 0,0,0) -> Letter=010 one cycle after the 3rd trailing 0.
- Mark of 2 units (1,1,0) -> ErrorOut=1 one cycle after the 0 sample. Then 0,0,1,0,0,0 -> ErrorOut pulses once; the stream remains in DRAIN through the 1 and returns to IDLE after 3 zeros.
- Five dots (1,0,1,0,1,0,1,0,1,0) -> ErrorOut after the 5th dot's 0 sample; no LetterValid.
- Reset=1 mid-letter (after 1,0,1) -> all outputs 0, Letter=000. Then E (1,0,0,0) -> Letter=100, no stale symbols.
- NewBitIn held low 50 cycles mid-dash with DotDashIn toggling -> no state change. Resume the strobe -> correct letter decoded.
